// File: rtl/conv_stat_pkg.sv
// Shared types and helpers for the convolution result streamer:
// stream word kinds, streamer FSM states and the frame header encoder.
package conv_stat_pkg;

  typedef enum logic [1:0] {
    KIND_HEADER = 2'd0,
    KIND_ELEM   = 2'd1,
    KIND_COUNT  = 2'd2
  } stream_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_COUNT
  } state_t;

  function automatic logic [31:0] make_header(input logic [15:0] rows, input logic [15:0] cols);
    return {rows, cols};
  endfunction

endpackage

// File: rtl/conv_result_streamer_if.sv
// Valid/ready word stream from the result streamer toward the host side.
interface conv_result_streamer_if import conv_stat_pkg::*; #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] out_data;
  stream_kind_t      out_kind;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data, out_kind, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_kind, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/conv_stat_accum.sv
// Signed running max / sum of streamed elements; sum carries 8 guard bits
// so up to 256 elements cannot wrap.
module conv_stat_accum #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     update,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] elem,
  output logic signed [DATA_W-1:0] max_q,
  output logic signed [DATA_W+7:0] sum_q
);

  function automatic logic signed [DATA_W+7:0] sext(input logic signed [DATA_W-1:0] v);
    return {{8{v[DATA_W-1]}}, v};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      sum_q <= '0;
    end else if (clear) begin
      max_q <= '0;
      sum_q <= '0;
    end else if (update) begin
      if (first) begin
        max_q <= elem;
        sum_q <= sext(elem);
      end else begin
        if (elem > max_q) max_q <= elem;
        sum_q <= sum_q + sext(elem);
      end
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a finished result matrix on the producer's done edge and streams it
// as header / row-major elements / cycle count over a valid/ready interface.
module conv_result_streamer import conv_stat_pkg::*; #(
  parameter int ROWS   = 8,
  parameter int COLS   = 10,
  parameter int DATA_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    src_done,
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]   src_result,
  input  logic [31:0]                             src_cycle_count,
  conv_result_streamer_if.master                  st,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    drop_pulse,
  output logic signed [DATA_W-1:0]                stat_max,
  output logic signed [DATA_W+7:0]                stat_sum,
  output logic                                    stat_valid
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t                                state, state_d;
  logic                                  src_done_q;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] res_q;
  logic [31:0]                           cnt_q;
  logic [RW-1:0]                         row;
  logic [CW-1:0]                         col;
  logic                                  rise, hs, last_elem;
  logic                                  capture, drop_d, done_d;

  assign rise         = src_done & ~src_done_q;
  assign st.out_valid = (state != ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign hs           = st.out_valid & st.out_ready;
  assign last_elem    = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

  always_comb begin
    state_d     = state;
    capture     = 1'b0;
    drop_d      = 1'b0;
    done_d      = 1'b0;
    st.out_data = '0;
    st.out_kind = KIND_HEADER;
    st.out_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          capture = 1'b1;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        st.out_data = DATA_W'(make_header(16'(ROWS), 16'(COLS)));
        if (hs) state_d = ST_DATA;
      end
      ST_DATA: begin
        st.out_data = res_q[row][col];
        st.out_kind = KIND_ELEM;
        if (hs && last_elem) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        st.out_data = DATA_W'(cnt_q);
        st.out_kind = KIND_COUNT;
        st.out_last = 1'b1;
        if (hs) begin
          done_d = 1'b1;
          // A rise landing on the final handshake starts the next frame directly.
          if (rise) begin
            capture = 1'b1;
            state_d = ST_HEADER;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rise && (state != ST_IDLE) && !capture) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_done_q <= 1'b0;
      res_q      <= '0;
      cnt_q      <= '0;
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      drop_pulse <= 1'b0;
      stat_valid <= 1'b0;
    end else begin
      state      <= state_d;
      src_done_q <= src_done;
      frame_done <= done_d;
      drop_pulse <= drop_d;
      if (capture) begin
        res_q      <= src_result;
        cnt_q      <= src_cycle_count;
        row        <= '0;
        col        <= '0;
        stat_valid <= 1'b0;
      end else begin
        if (done_d) stat_valid <= 1'b1;
        if (state == ST_DATA && hs) begin
          if (col == CW'(COLS - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  conv_stat_accum #(.DATA_W(DATA_W)) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (capture),
    .update ((state == ST_DATA) && hs),
    .first  ((row == '0) && (col == '0)),
    .elem   ($signed(res_q[row][col])),
    .max_q  (stat_max),
    .sum_q  (stat_sum)
  );

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized bench for conv_result_streamer against a queue-based frame model.
module tb_conv_result_streamer;
  import conv_stat_pkg::*;

  localparam int ROWS   = 8;
  localparam int COLS   = 10;
  localparam int DATA_W = 32;
  localparam int NWORDS = ROWS * COLS + 2;

  typedef struct packed {
    logic [1:0]        kind;
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic src_done = 1'b0;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] src_result = '0;
  logic [31:0] src_cycle_count = '0;
  logic busy, frame_done, drop_pulse, stat_valid;
  logic signed [DATA_W-1:0] stat_max;
  logic signed [DATA_W+7:0] stat_sum;

  conv_result_streamer_if #(.DATA_W(DATA_W)) st ();

  conv_result_streamer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_done        (src_done),
    .src_result      (src_result),
    .src_cycle_count (src_cycle_count),
    .st              (st),
    .busy            (busy),
    .frame_done      (frame_done),
    .drop_pulse      (drop_pulse),
    .stat_max        (stat_max),
    .stat_sum        (stat_sum),
    .stat_valid      (stat_valid)
  );

  word_t got_q[$];
  word_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int hold_err = 0, fd_cnt = 0, drop_cnt = 0, ready_low_pct = 0;
  logic pend = 1'b0;
  word_t pend_w;
  logic signed [DATA_W-1:0] exp_max;
  logic signed [DATA_W+7:0] exp_sum;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    st.out_ready = ($urandom_range(0, 99) >= ready_low_pct);
  end

  function automatic word_t cur_word();
    word_t w;
    w.kind = st.out_kind;
    w.last = st.out_last;
    w.data = st.out_data;
    return w;
  endfunction

  // Observer: records accepted words, pulse counts and hold-while-stalled violations.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && !(st.out_valid && cur_word() == pend_w)) hold_err++;
      pend   = st.out_valid && !st.out_ready;
      pend_w = cur_word();
      if (st.out_valid && st.out_ready) got_q.push_back(cur_word());
      if (frame_done) fd_cnt++;
      if (drop_pulse) drop_cnt++;
    end
  end

  // Reference: one frame is header, ROWS*COLS elements row-major, then the count.
  task automatic add_frame();
    word_t  w;
    longint s = 0;
    int     m = 0;
    int     e;
    w.kind = 2'd0; w.last = 1'b0; w.data = DATA_W'((ROWS << 16) | COLS);
    exp_q.push_back(w);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e = $signed(src_result[r][c]);
        if (r == 0 && c == 0) m = e;
        else if (e > m) m = e;
        s += e;
        w.kind = 2'd1; w.last = 1'b0; w.data = src_result[r][c];
        exp_q.push_back(w);
      end
    w.kind = 2'd2; w.last = 1'b1; w.data = src_cycle_count;
    exp_q.push_back(w);
    exp_max = m;
    exp_sum = s[DATA_W+7:0];
  endtask

  task automatic score(output int bad);
    int n;
    bad = (got_q.size() != exp_q.size()) ? 1000 : 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 src_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 src_done = 1'b0;
  endtask

  task automatic wait_frames(input int target, output bit to);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    to = (fd_cnt < target);
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) src_result[r][c] = $urandom;
    src_cycle_count = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (st.out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: valid=%b busy=%b, need 0 0", st.out_valid, busy);
    end
    vectors++;
    if (frame_done !== 1'b0 || drop_pulse !== 1'b0 || stat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: done=%b drop=%b sv=%b, need 0", frame_done, drop_pulse, stat_valid);
    end
    vectors++;
    if (stat_max !== '0 || stat_sum !== '0 || st.out_data !== '0 || st.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: max=%0d sum=%0d data=%h last=%b, need 0", stat_max, stat_sum, st.out_data, st.out_last);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to; int bad; int f0;
    ready_low_pct = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) src_result[r][c] = DATA_W'(r * 16 + c);
    src_cycle_count = 32'd1234;
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt;
    pulse_done();
    wait_frames(f0 + 1, to);
    repeat (4) @(negedge clk);
    score(bad);
    vectors++;
    if (to || bad !== 0) begin
      miscompares++;
      $display("FAIL basic_words: timeout=%0d bad=%0d got %0d words, need %0d", to, bad, got_q.size(), NWORDS);
    end
    vectors++;
    if (got_q.size() > 0 && got_q[0].data !== 32'h0008000A) begin
      miscompares++;
      $display("FAIL basic_header: got %h, need 0008000a", got_q[0].data);
    end
    vectors++;
    if (fd_cnt - f0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done_pulse: %0d cycles high, need 1", fd_cnt - f0);
    end
    vectors++;
    if (stat_max !== 32'sh79 || stat_max !== exp_max) begin
      miscompares++;
      $display("FAIL basic_max: got %0d, need %0d", stat_max, exp_max);
    end
    vectors++;
    if (stat_sum !== exp_sum || stat_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_sum: got %0d sv=%b, need %0d sv=1", stat_sum, stat_valid, exp_sum);
    end
  endtask

  task automatic test_backpressure();
    bit to; int bad; int f0, h0;
    ready_low_pct = 30;
    fill_random();
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt; h0 = hold_err;
    pulse_done();
    wait_frames(f0 + 1, to);
    score(bad);
    vectors++;
    if (to || bad !== 0) begin
      miscompares++;
      $display("FAIL bp_words: timeout=%0d bad=%0d got %0d words, need %0d", to, bad, got_q.size(), NWORDS);
    end
    vectors++;
    if (hold_err - h0 !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d stalled words changed, need 0", hold_err - h0);
    end
    vectors++;
    if (stat_max !== exp_max || stat_sum !== exp_sum) begin
      miscompares++;
      $display("FAIL bp_stats: max=%0d sum=%0d, need %0d %0d", stat_max, stat_sum, exp_max, exp_sum);
    end
    ready_low_pct = 0;
  endtask

  task automatic test_signed();
    bit to; int f0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) src_result[r][c] = DATA_W'(-5);
    src_result[3][4] = DATA_W'(-1);
    src_cycle_count = $urandom;
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt;
    pulse_done();
    wait_frames(f0 + 1, to);
    vectors++;
    if (to || stat_max !== -32'sd1 || stat_max !== exp_max) begin
      miscompares++;
      $display("FAIL signed_max: timeout=%0d got %0d, need -1", to, stat_max);
    end
    vectors++;
    if (stat_sum !== -40'sd396 || stat_sum !== exp_sum) begin
      miscompares++;
      $display("FAIL signed_sum: got %0d, need -396", stat_sum);
    end
  endtask

  task automatic test_busy_retrigger();
    bit to; int bad; int f0, d0, n;
    ready_low_pct = 30;
    fill_random();
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt; d0 = drop_cnt;
    pulse_done();
    n = 0;
    while (got_q.size() < 20 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1 src_done = 1'b1;
    @(posedge clk); #1 src_done = 1'b0;
    fill_random();
    wait_frames(f0 + 1, to);
    score(bad);
    vectors++;
    if (to || bad !== 0) begin
      miscompares++;
      $display("FAIL retrig_frame: timeout=%0d bad=%0d words", to, bad);
    end
    vectors++;
    if (drop_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL retrig_drop: %0d drop pulses, need 1", drop_cnt - d0);
    end

    // Rise coincident with the final handshake chains a second frame.
    ready_low_pct = 0;
    repeat (2) @(posedge clk);
    fill_random();
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt; d0 = drop_cnt;
    pulse_done();
    n = 0;
    @(negedge clk);
    while (!(st.out_valid && st.out_kind == KIND_COUNT && st.out_ready) && n < 2000) begin
      @(negedge clk); n++;
    end
    fill_random();
    add_frame();
    src_done = 1'b1;
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || st.out_kind !== KIND_HEADER || stat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL chain_start: done=%b busy=%b kind=%0d sv=%b, need 1 1 0 0", frame_done, busy, st.out_kind, stat_valid);
    end
    @(posedge clk); #1 src_done = 1'b0;
    wait_frames(f0 + 2, to);
    score(bad);
    vectors++;
    if (to || bad !== 0 || drop_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL chain_frames: timeout=%0d bad=%0d drops=%0d, need 0 0 0", to, bad, drop_cnt - d0);
    end
    vectors++;
    if (stat_max !== exp_max || stat_sum !== exp_sum || stat_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL chain_stats: max=%0d sum=%0d sv=%b, need %0d %0d 1", stat_max, stat_sum, stat_valid, exp_max, exp_sum);
    end
  endtask

  task automatic test_held_done();
    int bad; int f0, d0;
    ready_low_pct = 30;
    fill_random();
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt; d0 = drop_cnt;
    @(posedge clk); #1 src_done = 1'b1;
    repeat (500) @(posedge clk);
    #1 src_done = 1'b0;
    repeat (5) @(negedge clk);
    score(bad);
    vectors++;
    if (fd_cnt - f0 !== 1 || drop_cnt - d0 !== 0 || bad !== 0) begin
      miscompares++;
      $display("FAIL held_done: frames=%0d drops=%0d bad=%0d, need 1 0 0", fd_cnt - f0, drop_cnt - d0, bad);
    end
    ready_low_pct = 0;
  endtask

  task automatic test_reset_midframe();
    bit to; int bad; int f0, n;
    ready_low_pct = 0;
    fill_random();
    got_q.delete(); exp_q.delete();
    pulse_done();
    n = 0;
    while (got_q.size() < 41 && n < 2000) begin @(negedge clk); n++; end
    vectors++;
    if (st.out_valid !== 1'b1 || n >= 2000) begin
      miscompares++;
      $display("FAIL midrst_pre: valid=%b words=%0d, need 1 41", st.out_valid, got_q.size());
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (st.out_valid !== 1'b0 || busy !== 1'b0 || stat_max !== '0 || stat_sum !== '0 || st.out_data !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: valid=%b busy=%b max=%0d sum=%0d data=%h, need 0", st.out_valid, busy, stat_max, stat_sum, st.out_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    fill_random();
    got_q.delete(); exp_q.delete(); add_frame();
    f0 = fd_cnt;
    pulse_done();
    wait_frames(f0 + 1, to);
    score(bad);
    vectors++;
    if (to || bad !== 0 || stat_sum !== exp_sum || stat_max !== exp_max) begin
      miscompares++;
      $display("FAIL midrst_refill: timeout=%0d bad=%0d sum=%0d need %0d", to, bad, stat_sum, exp_sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_signed();
    test_busy_retrigger();
    test_held_done();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
